// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
//   Shares the single register-file write port between the ALU write-back
//   path and the load/store unit. The granted write is registered, so it
//   reaches the register file one cycle after its handshake. The LSU has
//   priority. An ALU request that has lost STARVE_LIMIT consecutive cycles
//   is force-granted.
//
//   Optional feature, macro RF_SCOREBOARD_EN:
//     defined     - a pending-load busy vector is kept for decode load-use checks.
//     not defined - sb_set/sb_set_rd are ignored and sb_busy_rs1/rs2 read 0.
//
// Ports
//   clock, reset                     clock, synchronous active-high reset
//   alu_valid/ready/rd/data          ALU write-back request (ready is combinational)
//   lsu_valid/ready/rd/data          LSU write-back request (ready is combinational)
//   rf_write_enable/addr_rd/data_rd  registered register-file write port
//   sb_set, sb_set_rd                decode issued a load to sb_set_rd
//   sb_query_rs1/rs2                 decode source operands
//   sb_busy_rs1/rs2                  operand has a load write outstanding
module regfile_wb_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        alu_valid,
    output logic        alu_ready,
    input  logic [4:0]  alu_rd,
    input  logic [31:0] alu_data,
    input  logic        lsu_valid,
    output logic        lsu_ready,
    input  logic [4:0]  lsu_rd,
    input  logic [31:0] lsu_data,
    output logic        rf_write_enable,
    output logic [4:0]  rf_addr_rd,
    output logic [31:0] rf_data_rd,
    input  logic        sb_set,
    input  logic [4:0]  sb_set_rd,
    input  logic [4:0]  sb_query_rs1,
    input  logic [4:0]  sb_query_rs2,
    output logic        sb_busy_rs1,
    output logic        sb_busy_rs2
);

    logic [3:0]  r_starve_cnt;
    logic        r_wb_is_lsu;
    logic        w_force_alu;
    logic        w_alu_xfer;
    logic        w_lsu_xfer;
    logic [4:0]  w_win_rd;
    logic [31:0] w_win_data;

    // A waiting ALU request that has hit the limit takes the port from the LSU.
    assign w_force_alu = alu_valid && (r_starve_cnt == 4'(STARVE_LIMIT));

    assign alu_ready  = !reset && alu_valid && (!lsu_valid || w_force_alu);
    assign lsu_ready  = !reset && lsu_valid && !w_force_alu;
    assign w_alu_xfer = alu_ready;
    assign w_lsu_xfer = lsu_ready;

    assign w_win_rd   = w_lsu_xfer ? lsu_rd   : alu_rd;
    assign w_win_data = w_lsu_xfer ? lsu_data : alu_data;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_starve_cnt <= 4'd0;
        end else if (!alu_valid || w_alu_xfer) begin
            r_starve_cnt <= 4'd0;
        end else if (r_starve_cnt != 4'(STARVE_LIMIT)) begin
            r_starve_cnt <= r_starve_cnt + 4'd1;
        end
    end

    // Writes to x0 are accepted but never raise the write enable.
    always_ff @(posedge clock) begin
        if (reset) begin
            rf_write_enable <= 1'b0;
            rf_addr_rd      <= 5'd0;
            rf_data_rd      <= 32'd0;
            r_wb_is_lsu     <= 1'b0;
        end else begin
            rf_write_enable <= (w_alu_xfer || w_lsu_xfer) && (w_win_rd != 5'd0);
            if (w_alu_xfer || w_lsu_xfer) begin
                rf_addr_rd  <= w_win_rd;
                rf_data_rd  <= w_win_data;
                r_wb_is_lsu <= w_lsu_xfer;
            end
        end
    end

`ifdef RF_SCOREBOARD_EN
    logic [31:0] r_busy;
    logic [31:0] w_busy_nxt;

    // The clear lands with the register-file commit; a same-cycle set wins.
    always_comb begin
        w_busy_nxt = r_busy;
        if (rf_write_enable && r_wb_is_lsu) begin
            w_busy_nxt[rf_addr_rd] = 1'b0;
        end
        if (sb_set) begin
            w_busy_nxt[sb_set_rd] = 1'b1;
        end
        w_busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_busy <= 32'd0;
        end else begin
            r_busy <= w_busy_nxt;
        end
    end

    assign sb_busy_rs1 = r_busy[sb_query_rs1];
    assign sb_busy_rs2 = r_busy[sb_query_rs2];
`else
    logic w_unused;
    assign w_unused    = ^{sb_set, sb_set_rd, sb_query_rs1, sb_query_rs2, r_wb_is_lsu};
    assign sb_busy_rs1 = 1'b0;
    assign sb_busy_rs2 = 1'b0;
`endif

endmodule
